// File: rtl/jt51_dacser_pkg.sv
// Shared constants, state type and helpers for the jt51 serial DAC output stage.
package jt51_dacser_pkg;

  localparam int FRAME_W   = 32;
  localparam int WORD_W    = 16;
  localparam int MAN_W     = 10;
  localparam int EXP_W     = 3;

  localparam int SH1_START = 8;
  localparam int SH1_END   = 15;
  localparam int SH2_START = 24;
  localparam int SH2_END   = 31;
  localparam int MAN_OFS   = 3;
  localparam int EXP_OFS   = 13;

  typedef enum logic {
    SEEK,
    RUN
  } state_t;

  // Place mantissa and exponent into a 16-slot channel word, slot 0 in bit 0.
  function automatic logic [WORD_W-1:0] pack_word(input logic [MAN_W-1:0] man,
                                                  input logic [EXP_W-1:0] exp);
    pack_word = '0;
    pack_word[MAN_OFS +: MAN_W] = man;
    pack_word[EXP_OFS +: EXP_W] = exp;
  endfunction

  // True when a slot number lies inside an inclusive strobe window.
  function automatic logic in_window(input int slot, input int lo, input int hi);
    in_window = (slot >= lo) && (slot <= hi);
  endfunction

endpackage

// File: rtl/jt51_dacser_if.sv
// Sample input and YM3012-style serial DAC bus between the accumulator side and the DAC.
interface jt51_dacser_if;
  logic               sample_stb;
  logic signed [15:0] left;
  logic signed [15:0] right;
  logic               so;
  logic               sh1;
  logic               sh2;
  logic               dac_clk;
  logic               miss;

  modport master (
    output sample_stb, left, right,
    input  so, sh1, sh2, dac_clk, miss
  );

  modport slave (
    input  sample_stb, left, right,
    output so, sh1, sh2, dac_clk, miss
  );
endinterface

// File: rtl/jt51_dacser_fp.sv
// Combinational signed 16-bit linear to 10-bit mantissa / 3-bit exponent converter.
module jt51_dacser_fp
  import jt51_dacser_pkg::*;
(
  input  logic signed [15:0]      lin,
  output logic        [MAN_W-1:0] man,
  output logic        [EXP_W-1:0] exp
);

  logic signed [15:0] shifted;
  logic               found;

  // Pick the smallest shift that brings the sample into signed 10-bit range; truncate, never round.
  always_comb begin
    man     = '0;
    exp     = '0;
    found   = 1'b0;
    shifted = '0;
    for (int i = 0; i < 7; i++) begin
      shifted = lin >>> i;
      if (!found && (shifted[15:9] == {7{shifted[9]}})) begin
        found = 1'b1;
        man   = shifted[MAN_W-1:0];
        exp   = EXP_W'(i + 1);
      end
    end
  end

endmodule

// File: rtl/jt51_dacser.sv
// Serializer: holds the latest sample pair, converts it to float at each frame boundary
// and shifts both channel words out LSB-first with sh1/sh2 latch strobes.
module jt51_dacser
  import jt51_dacser_pkg::*;
#(
  parameter int FRAME_TICKS = 64
)
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clk_en,
  jt51_dacser_if.slave   bus
);

  localparam logic [5:0] LAST_TICK = 6'(FRAME_TICKS - 1);

  state_t              state_q, state_d;
  logic [5:0]          tick_q, tick_d;
  logic [FRAME_W-1:0]  sr_q, sr_d;
  logic [WORD_W-1:0]   hold_l_q, hold_l_d;
  logic [WORD_W-1:0]   hold_r_q, hold_r_d;
  logic                pending_q, pending_d;
  logic                miss_q, miss_d;

  logic                run;
  logic                stb;
  logic                at_load;
  logic                bypass;
  logic [4:0]          slot;
  logic [WORD_W-1:0]   src_l, src_r;
  logic [MAN_W-1:0]    man_l, man_r;
  logic [EXP_W-1:0]    exp_l, exp_r;

  assign run     = (state_q == RUN);
  assign stb     = clk_en & bus.sample_stb;
  assign at_load = run && (tick_q == LAST_TICK);
  assign bypass  = at_load & stb;
  assign slot    = tick_q[5:1];

  // A strobe landing on the load tick goes straight into the frame instead of waiting a frame.
  assign src_l = bypass ? bus.left  : hold_l_q;
  assign src_r = bypass ? bus.right : hold_r_q;

  jt51_dacser_fp u_fp_l (
    .lin (src_l),
    .man (man_l),
    .exp (exp_l)
  );

  jt51_dacser_fp u_fp_r (
    .lin (src_r),
    .man (man_r),
    .exp (exp_r)
  );

  // Outputs derive from state so an async reset forces them low immediately.
  assign bus.so      = run & sr_q[0];
  assign bus.dac_clk = run & tick_q[0];
  assign bus.sh1     = run & in_window(int'(slot), SH1_START, SH1_END);
  assign bus.sh2     = run & in_window(int'(slot), SH2_START, SH2_END);
  assign bus.miss    = miss_q;

  // Next-state logic: seek for the first sample, then free-run the frame with load at wrap.
  always_comb begin
    state_d   = state_q;
    tick_d    = tick_q;
    sr_d      = sr_q;
    hold_l_d  = hold_l_q;
    hold_r_d  = hold_r_q;
    pending_d = pending_q;
    miss_d    = miss_q;
    if (clk_en) begin
      miss_d = 1'b0;
      unique case (state_q)
        SEEK: begin
          if (bus.sample_stb) begin
            state_d   = RUN;
            tick_d    = LAST_TICK;
            hold_l_d  = bus.left;
            hold_r_d  = bus.right;
            pending_d = 1'b1;
          end
        end
        RUN: begin
          tick_d = tick_q + 6'd1;
          if (at_load) begin
            sr_d      = {pack_word(man_r, exp_r), pack_word(man_l, exp_l)};
            pending_d = 1'b0;
            // Holding keeps tracking the last accepted pair so an idle frame repeats it.
            if (bus.sample_stb) begin
              hold_l_d = bus.left;
              hold_r_d = bus.right;
            end
          end else begin
            if (tick_q[0]) begin
              sr_d = sr_q >> 1;
            end
            if (bus.sample_stb) begin
              hold_l_d  = bus.left;
              hold_r_d  = bus.right;
              pending_d = 1'b1;
              miss_d    = pending_q;
            end
          end
        end
        default: state_d = SEEK;
      endcase
    end
  end

  // State register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= SEEK;
      tick_q    <= '0;
      sr_q      <= '0;
      hold_l_q  <= '0;
      hold_r_q  <= '0;
      pending_q <= 1'b0;
      miss_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_d;
      sr_q      <= sr_d;
      hold_l_q  <= hold_l_d;
      hold_r_q  <= hold_r_d;
      pending_q <= pending_d;
      miss_q    <= miss_d;
    end
  end

endmodule
